// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with registered decode for the text renderer,
// plus monitor hsync/vsync/de delayed to line up with the renderer's RGB output.
module vga_timing #(
    parameter int   H_VISIBLE = 720,
    parameter int   H_FRONT   = 18,
    parameter int   H_SYNC    = 108,
    parameter int   H_BACK    = 54,
    parameter int   V_VISIBLE = 400,
    parameter int   V_FRONT   = 12,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 35,
    parameter logic H_POL     = 1'b0,
    parameter logic V_POL     = 1'b1,
    parameter int   SYNC_DLY  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        h_active,
    output logic        v_active,
    output logic        eol,
    output logic        frame_start,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        de
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
    localparam logic [11:0] HS_ON  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_OFF = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_ON  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_OFF = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [11:0] hc, vc;
    logic        hs_raw, vs_raw, de_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= (hc == H_LAST) ? 12'd0 : hc + 12'd1;
            if (hc == H_LAST)
                vc <= (vc == V_LAST) ? 12'd0 : vc + 12'd1;
        end
    end

    // stage 1: every strobe describes the counter value of the previous cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcount      <= '0;
            vcount      <= '0;
            h_active    <= 1'b0;
            v_active    <= 1'b0;
            eol         <= 1'b0;
            frame_start <= 1'b0;
            hs_raw      <= !H_POL;
            vs_raw      <= !V_POL;
            de_raw      <= 1'b0;
        end else begin
            hcount      <= hc;
            vcount      <= vc;
            h_active    <= hc < H_VIS;
            v_active    <= vc < V_VIS;
            eol         <= hc == H_VIS;
            frame_start <= (hc == 12'd0) && (vc == 12'd0);
            hs_raw      <= (hc >= HS_ON && hc < HS_OFF) ? H_POL : !H_POL;
            vs_raw      <= (vc >= VS_ON && vc < VS_OFF) ? V_POL : !V_POL;
            de_raw      <= (hc < H_VIS) && (vc < V_VIS);
        end
    end

    if (SYNC_DLY == 0) begin : g_nodly
        assign hsync = hs_raw;
        assign vsync = vs_raw;
        assign de    = de_raw;
    end else begin : g_dly
        logic [SYNC_DLY-1:0] hs_sr, vs_sr, de_sr;
        // presetting to the inactive levels keeps the monitor from seeing a sync glitch after reset
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hs_sr <= {SYNC_DLY{!H_POL}};
                vs_sr <= {SYNC_DLY{!V_POL}};
                de_sr <= '0;
            end else begin
                hs_sr <= SYNC_DLY'({hs_sr, hs_raw});
                vs_sr <= SYNC_DLY'({vs_sr, vs_raw});
                de_sr <= SYNC_DLY'({de_sr, de_raw});
            end
        end
        assign hsync = hs_sr[SYNC_DLY-1];
        assign vsync = vs_sr[SYNC_DLY-1];
        assign de    = de_sr[SYNC_DLY-1];
    end
endmodule
